imm_extend_pipe: RTL and testbench

Parametrised immediate-extraction and extension stage for the LEGv8 datapath. It takes a raw 32-bit instruction and an immediate-mode select, then extracts one of five immediate fields. The field is sign- or zero-extended (and shifted where the mode requires) to DATA_W bits. The result is registered behind a valid/ready skid buffer so decode can stall without losing an instruction; the sideband tag travels with the data.

---
 rtl/imm_ext_pkg.sv | 47 ++++
 rtl/imm_extract.sv | 85 ++++++++
 rtl/imm_extend_pipe.sv | 129 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared definitions for the LEGv8 immediate extraction stage.
//               Holds the immediate-mode encoding and the bit positions of
//               every immediate field inside a raw 32-bit instruction.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

  // Immediate-mode select; codes 5..7 are illegal
  typedef enum logic [2:0] {
    IMM12  = 3'd0,
    DADDR9 = 3'd1,
    COND19 = 3'd2,
    BR26   = 3'd3,
    MOVZ16 = 3'd4
  } imm_mode_t;

  // Field positions inside the instruction word
  localparam int c_IMM12_MSB  = 21;
  localparam int c_IMM12_LSB  = 10;
  localparam int c_DADDR9_MSB = 20;
  localparam int c_DADDR9_LSB = 12;
  localparam int c_COND19_MSB = 23;
  localparam int c_COND19_LSB = 5;
  localparam int c_BR26_MSB   = 25;
  localparam int c_BR26_LSB   = 0;
  localparam int c_MOVZ16_MSB = 20;
  localparam int c_MOVZ16_LSB = 5;

  // MOVZ half-word select (shift = 16 * hw)
  localparam int c_MOVZ_HW_MSB = 22;
  localparam int c_MOVZ_HW_LSB = 21;

  // Field widths
  localparam int c_IMM12_W  = c_IMM12_MSB  - c_IMM12_LSB  + 1;
  localparam int c_DADDR9_W = c_DADDR9_MSB - c_DADDR9_LSB + 1;
  localparam int c_COND19_W = c_COND19_MSB - c_COND19_LSB + 1;
  localparam int c_BR26_W   = c_BR26_MSB   - c_BR26_LSB   + 1;
  localparam int c_MOVZ16_W = c_MOVZ16_MSB - c_MOVZ16_LSB + 1;

  // Width of the internal working value before truncation to DATA_W
  localparam int c_WIDE_W = 64;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
// Module      : imm_extract
// Description : Combinational immediate extraction and extension. Selects one
//               of five immediate fields, sign/zero-extends it, applies the
//               branch or MOVZ shift and truncates to DATA_W bits.
// Ports       : instr_i  - raw 32-bit instruction
//               mode_i   - immediate mode (imm_mode_t code)
//               imm_o    - extended immediate, DATA_W bits
//               err_o    - illegal mode or MOVZ shift outside DATA_W
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extract
  import imm_ext_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int BR_SHIFT = 1
) (
  input  logic [31:0]       instr_i,
  input  logic [2:0]        mode_i,
  output logic [DATA_W-1:0] imm_o,
  output logic              err_o
);

  localparam logic [6:0] c_DATA_W = 7'(DATA_W);

  logic [c_WIDE_W-1:0] w_wide;
  logic [1:0]          w_hw;
  logic [6:0]          w_shamt;
  logic                w_unused_ok;

  assign w_hw    = instr_i[c_MOVZ_HW_MSB:c_MOVZ_HW_LSB];
  assign w_shamt = {1'b0, w_hw, 4'b0000};

  // Everything is built at 64 bits and truncated afterwards: the low DATA_W
  // bits of a 64-bit sign-extend-and-shift equal the DATA_W-bit result, and
  // shifted-out bits above DATA_W-1 are discarded as required.
  always_comb begin
    w_wide = '0;
    err_o  = 1'b0;
    case (mode_i)
      IMM12: begin
        w_wide = {{(c_WIDE_W-c_IMM12_W){1'b0}}, instr_i[c_IMM12_MSB:c_IMM12_LSB]};
      end
      DADDR9: begin
        w_wide = {{(c_WIDE_W-c_DADDR9_W){instr_i[c_DADDR9_MSB]}},
                  instr_i[c_DADDR9_MSB:c_DADDR9_LSB]};
      end
      COND19: begin
        w_wide = {{(c_WIDE_W-c_COND19_W){instr_i[c_COND19_MSB]}},
                  instr_i[c_COND19_MSB:c_COND19_LSB]};
        if (BR_SHIFT != 0) begin
          w_wide = w_wide << 2;
        end
      end
      BR26: begin
        w_wide = {{(c_WIDE_W-c_BR26_W){instr_i[c_BR26_MSB]}},
                  instr_i[c_BR26_MSB:c_BR26_LSB]};
        if (BR_SHIFT != 0) begin
          w_wide = w_wide << 2;
        end
      end
      MOVZ16: begin
        // A half-word placed entirely above the result width cannot be
        // represented; flag it and return zero.
        if (w_shamt >= c_DATA_W) begin
          err_o = 1'b1;
        end else begin
          w_wide = {{(c_WIDE_W-c_MOVZ16_W){1'b0}},
                    instr_i[c_MOVZ16_MSB:c_MOVZ16_LSB]} << w_shamt;
        end
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end

  assign imm_o = w_wide[DATA_W-1:0];

  // Opcode bits and (for narrow builds) upper working bits are not needed
  assign w_unused_ok = &{1'b0, instr_i[31:26], w_wide};

endmodule : imm_extract
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Immediate extraction stage with a registered output behind a
//               two-entry valid/ready skid buffer (output register + skid
//               register). The sideband tag travels with the immediate.
// Ports       : clk, reset_n          - clock, async active-low reset
//               in_valid/in_ready     - input handshake (in_ready registered)
//               in_instr/in_mode/in_tag - instruction, mode, sideband tag
//               out_valid/out_ready   - output handshake
//               out_imm/out_tag/out_err - result, aligned tag, error flag
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 5,
  parameter int BR_SHIFT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [2:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  logic [DATA_W-1:0] w_imm;
  logic              w_err;
  logic              w_in_fire;
  logic              w_out_free;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_imm_q,   out_imm_d;
  logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
  logic              out_err_q,   out_err_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0]  skid_tag_q,   skid_tag_d;
  logic              skid_err_q,   skid_err_d;

  imm_extract #(
    .DATA_W   (DATA_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_extract (
    .instr_i (in_instr),
    .mode_i  (in_mode),
    .imm_o   (w_imm),
    .err_o   (w_err)
  );

  // Ready depends only on the skid register, so there is no combinational
  // path from out_ready to in_ready.
  assign in_ready   = !skid_valid_q;
  assign w_in_fire  = in_valid && in_ready;
  // Output register can take new data when empty or being drained this edge
  assign w_out_free = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;

    if (w_out_free) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so no input competes here
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (w_in_fire) begin
        out_valid_d = 1'b1;
        out_imm_d   = w_imm;
        out_tag_d   = in_tag;
        out_err_d   = w_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_in_fire) begin
      // Output stalled: park the new entry in the skid register
      skid_valid_d = 1'b1;
      skid_imm_d   = w_imm;
      skid_tag_d   = in_tag;
      skid_err_d   = w_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

endmodule : imm_extend_pipe
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Self-checking bench for imm_extend_pipe. A 64-bit and a 32-bit
//               instance share the same stimulus; a queue-based model tracks
//               accepted entries and computes the expected immediates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

  localparam int TAG_W    = 5;
  localparam int BR_SHIFT = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready,  in_ready32;
  logic        out_valid, out_valid32;
  logic [63:0] out_imm;
  logic [31:0] out_imm32;
  logic [4:0]  out_tag,   out_tag32;
  logic        out_err,   out_err32;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  mode;
    logic [4:0]  tag;
  } ent_t;

  ent_t       sb[$];
  logic [4:0] tag_log[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.DATA_W(64), .TAG_W(TAG_W), .BR_SHIFT(BR_SHIFT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
  );

  imm_extend_pipe #(.DATA_W(32), .TAG_W(TAG_W), .BR_SHIFT(BR_SHIFT)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: arithmetic on the field value, then truncate to dw bits.
  // Returns {err, imm}.
  function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] m, input int dw);
    longint      s;
    logic [63:0] mask;
    logic        err;
    int          hw;
    err  = 1'b0;
    s    = 0;
    mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
    case (m)
      3'd0: s = longint'((ins >> 10) & 32'h0000_0FFF);
      3'd1: begin
        s = longint'((ins >> 12) & 32'h0000_01FF);
        if (s >= 256) s = s - 512;
      end
      3'd2: begin
        s = longint'((ins >> 5) & 32'h0007_FFFF);
        if (s >= 262144) s = s - 524288;
        if (BR_SHIFT != 0) s = s * 4;
      end
      3'd3: begin
        s = longint'(ins & 32'h03FF_FFFF);
        if (s >= 33554432) s = s - 67108864;
        if (BR_SHIFT != 0) s = s * 4;
      end
      3'd4: begin
        hw = int'((ins >> 21) & 32'd3);
        if (16 * hw >= dw) err = 1'b1;
        else s = longint'((ins >> 5) & 32'h0000_FFFF) << (16 * hw);
      end
      default: err = 1'b1;
    endcase
    return {err, 64'(s) & mask};
  endfunction

  // Compare process: the queue holds every entry inside the DUT, oldest first
  always @(negedge clk) begin
    logic [64:0] e64;
    logic [64:0] e32;
    if (!reset_n) begin
      sb.delete();
    end else begin
      chk("in_ready",    {63'd0, in_ready},    {63'd0, sb.size() < 2});
      chk("in_ready32",  {63'd0, in_ready32},  {63'd0, sb.size() < 2});
      chk("out_valid",   {63'd0, out_valid},   {63'd0, sb.size() > 0});
      chk("out_valid32", {63'd0, out_valid32}, {63'd0, sb.size() > 0});
      if (sb.size() > 0 && out_valid) begin
        e64 = model(sb[0].instr, sb[0].mode, 64);
        e32 = model(sb[0].instr, sb[0].mode, 32);
        chk("imm64", out_imm, e64[63:0]);
        chk("err64", {63'd0, out_err}, {63'd0, e64[64]});
        chk("tag64", {59'd0, out_tag}, {59'd0, sb[0].tag});
        chk("imm32", {32'd0, out_imm32}, e32[63:0]);
        chk("err32", {63'd0, out_err32}, {63'd0, e32[64]});
        chk("tag32", {59'd0, out_tag32}, {59'd0, sb[0].tag});
        if (out_ready) begin
          tag_log.push_back(sb[0].tag);
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{instr: in_instr, mode: in_mode, tag: in_tag});
      end
    end
  end

  // All tasks start and end at posedge + 2
  task automatic send(input logic [31:0] ins, input logic [2:0] m, input logic [4:0] t);
    int n;
    in_instr = ins;
    in_mode  = m;
    in_tag   = t;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=in_ready_low exp=accept tag=%0d", t);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] order;
    int          n;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_imm",   out_imm,            64'd0);
    chk("rst_out_tag",   {59'd0, out_tag},   64'd0);
    chk("rst_out_err",   {63'd0, out_err},   64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    reset_n = 1'b1;
    @(posedge clk); #2;

    // Directed immediates, results visible one edge after acceptance
    send(32'h1FC << 12, 3'd1, 5'd1);
    chk("daddr9_neg", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("daddr9_err", {63'd0, out_err}, 64'd0);
    send(32'h0BC << 12, 3'd1, 5'd2);
    chk("daddr9_pos", out_imm, 64'h0000_0000_0000_00BC);
    send(32'h7FFFF << 5, 3'd2, 5'd3);
    chk("cond19_neg", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("cond19_32",  {32'd0, out_imm32}, 64'h0000_0000_FFFF_FFFC);
    send(32'h0000_0001, 3'd3, 5'd4);
    chk("br26_one", out_imm, 64'h4);
    send(32'hFFF << 10, 3'd0, 5'd5);
    chk("imm12_max", out_imm, 64'h0000_0000_0000_0FFF);
    send((32'hBEEF << 5) | (32'd2 << 21), 3'd4, 5'd6);
    chk("movz_hw2",     out_imm, 64'h0000_BEEF_0000_0000);
    chk("movz_hw2_err", {63'd0, out_err}, 64'd0);
    chk("movz32_imm",   {32'd0, out_imm32}, 64'd0);
    chk("movz32_err",   {63'd0, out_err32}, 64'd1);
    send(32'hFFFF_FFFF, 3'd6, 5'd7);
    chk("illegal_imm", out_imm, 64'd0);
    chk("illegal_err", {63'd0, out_err}, 64'd1);
    repeat (2) @(posedge clk);
    #2;

    // Backpressure: tags 1,2,3 back-to-back with the consumer stalled
    tag_log.delete();
    out_ready = 1'b0;
    in_instr  = $urandom;
    in_mode   = 3'd0;
    in_valid  = 1'b1;
    in_tag    = 5'd1;
    @(posedge clk); #2;
    in_tag = 5'd2;
    @(posedge clk); #2;
    in_tag = 5'd3;
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_out_tag",      {59'd0, out_tag},  64'd1);
    @(posedge clk); #2;
    chk("bp_in_ready_hold", {63'd0, in_ready}, 64'd0);
    chk("bp_out_tag_hold",  {59'd0, out_tag},  64'd1);
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("bp_count", 64'(tag_log.size()), 64'd3);
    if (tag_log.size() == 3) begin
      order = {tag_log[0], tag_log[1], tag_log[2]};
      chk("bp_order", {49'd0, order}, {49'd0, 5'd1, 5'd2, 5'd3});
    end

    // Full-throughput stream of 16 random instructions
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_instr = $urandom;
      in_mode  = 3'($urandom_range(0, 7));
      in_tag   = 5'($urandom);
      @(posedge clk); #2;
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    // Random traffic with random stalls
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      in_mode   = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom);
      @(posedge clk); #2;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    // Reset with both entries full
    out_ready = 1'b0;
    send(32'h1FC << 12, 3'd1, 5'd9);
    send(32'hFFF << 10, 3'd0, 5'd10);
    chk("rst_pre_full", {63'd0, in_ready}, 64'd0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_out_imm",   out_imm,            64'd0);
    chk("async_out_tag",   {59'd0, out_tag},   64'd0);
    chk("async_in_ready",  {63'd0, in_ready},  64'd1);
    @(posedge clk); #2;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk("post_rst_empty", {63'd0, out_valid}, 64'd0);
    end
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_imm_extend_pipe
`default_nettype wire
